shift_ctrl: RTL and testbench
=============================

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter N, default 8: word width; equals the width of the controlled shift register; N >= 2.
REQ-002 Parameter CW, default $clog2(N)+1: bit-counter width, derived and not overridden.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 start_valid  in  1  request to serialize data_in.
REQ-006 start_ready  out  1  controller accepts a request this cycle.
REQ-007 data_in  in  N  parallel word, sampled on accept.
REQ-008 msb_first  in  1  bit order, sampled on accept (1 = MSB first).
REQ-009 abort  in  1  cancel the transfer in progress.
REQ-010 ser_out  out  1  serial bit, drives shift register input I.
REQ-011 sr_direction  out  1  drives shift register direction.
REQ-012 sr_enable  out  1  drives shift register enable.
REQ-013 sr_q  in  N  shift register parallel output D.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done_valid  out  1  captured result available.
REQ-016 done_data  out  N  captured sr_q.
REQ-017 done_ready  in  1  consumer accepts the result.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, CAPTURE, DONE.
REQ-019 IDLE: start_ready=1, sr_enable=0; on start_valid&start_ready, latch data_in into word register, latch msb_first, clear counter, go to SHIFT.
REQ-020 SHIFT: sr_enable=1; ser_out = word[N-1] if msb_first else word[0]; sr_direction = latched msb_first.
REQ-021 SHIFT: each edge shifts word one place (left if msb_first, else right, zero fill) and increments counter; after exactly N SHIFT cycles, go to CAPTURE.
REQ-022 CAPTURE: one cycle, sr_enable=0; at its closing edge latch sr_q into done_data and go to DONE.
REQ-023 DONE: done_valid=1; done_data and done_valid SHALL hold stable until done_ready=1; on done_ready, go to IDLE.
REQ-024 Latency: accept at edge E0 -> sr_enable high for cycles E0..EN -> done_valid high from edge EN+1 (N+1 cycles).
REQ-025 start_valid outside IDLE SHALL be ignored; start_ready=0 outside IDLE; no request queuing.
REQ-026 done_ready outside DONE SHALL be ignored.
REQ-027 abort in SHIFT or CAPTURE: next state IDLE, sr_enable=0 from next cycle, done_valid never asserted, done_data unchanged; abort in IDLE or DONE ignored.
REQ-028 abort and counter terminal count in the same cycle: abort wins.
REQ-029 ser_out SHALL be 0 when not in SHIFT.
REQ-030 All outputs SHALL be registered or decoded directly from state; no combinational path from inputs to outputs.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, counter=0, word=0, done_data=0, ser_out=0, sr_enable=0, sr_direction=0, done_valid=0, busy=0; start_ready=1 while reset is deasserted and the FSM is in IDLE.
REQ-032 Reset mid-transfer SHALL discard the transfer; the first accept is possible at the first edge after release.

Structure
REQ-033 Shared package shift_ctrl_pkg SHALL hold state encoding localparams and default N.
REQ-034 Sub-module bit_counter (CW-bit, clear/increment/terminal-count at N-1) SHALL be instantiated once.

Verification
REQ-035 N=8, data_in=8'hA5, msb_first=1, behavioural shift register in loop -> ser_out 1,0,1,0,0,1,0,1; done_valid 9 cycles after accept; done_data=8'hA5.
REQ-036 data_in=8'h01, msb_first=0 -> ser_out 1 then seven 0s; sr_direction=0 throughout SHIFT.
REQ-037 done_ready held 0 for 5 cycles in DONE -> done_valid and done_data stable, start_ready=0, start_valid pulses ignored.
REQ-038 abort in 3rd SHIFT cycle -> sr_enable=0 next cycle, state IDLE, done_valid stays 0.
REQ-039 reset low during 5th SHIFT cycle -> all outputs at reset values without a clock edge; after release, new accept proceeds normally.
REQ-040 done_ready tied 1, start_valid tied 1 -> back-to-back words accepted every N+3 cycles.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serializing shift-register controller.
package shift_ctrl_pkg;

    localparam int unsigned DefaultN = 8;

    // State encodings, kept as named constants so other blocks can decode state words.
    localparam logic [1:0] EncIdle    = 2'd0;
    localparam logic [1:0] EncShift   = 2'd1;
    localparam logic [1:0] EncCapture = 2'd2;
    localparam logic [1:0] EncDone    = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = EncIdle,
        StShift   = EncShift,
        StCapture = EncCapture,
        StDone    = EncDone
    } state_e;

endpackage

// File: rtl/shift_ctrl_bit_counter.sv
// Bit counter: synchronous clear/increment, terminal count decoded from the register.
module bit_counter
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned CW   = 4,
    parameter int unsigned Last = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic tc
);

    logic [CW-1:0] count_q, count_d;

    // Clear takes priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (incr) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == Last[CW-1:0]);

endmodule

// File: rtl/shift_ctrl.sv
// Serializes a parallel word into an external shift register, then captures its
// parallel output and offers it on a valid/ready interface.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned  N  = DefaultN,
    localparam int unsigned CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] data_in,
    input  logic         msb_first,
    input  logic         abort,
    output logic         ser_out,
    output logic         sr_direction,
    output logic         sr_enable,
    input  logic [N-1:0] sr_q,
    output logic         busy,
    output logic         done_valid,
    output logic [N-1:0] done_data,
    input  logic         done_ready
);

    state_e       state_q, state_d;
    logic [N-1:0] word_q, word_d;
    logic [N-1:0] done_data_q, done_data_d;
    logic         msb_q, msb_d;
    logic         cnt_clear, cnt_incr, cnt_tc;

    bit_counter #(
        .CW   (CW),
        .Last (N - 1)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .tc    (cnt_tc)
    );

    // Next-state and datapath updates; abort beats terminal count.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        msb_d       = msb_q;
        done_data_d = done_data_q;
        cnt_clear   = 1'b0;
        cnt_incr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    word_d    = data_in;
                    msb_d     = msb_first;
                    cnt_clear = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    word_d   = msb_q ? {word_q[N-2:0], 1'b0} : {1'b0, word_q[N-1:1]};
                    cnt_incr = 1'b1;
                    if (cnt_tc) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    done_data_d = sr_q;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            word_q      <= '0;
            msb_q       <= 1'b0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            msb_q       <= msb_d;
            done_data_q <= done_data_d;
        end
    end

    // Outputs decoded only from registers, so inputs never reach them combinationally.
    assign start_ready  = (state_q == StIdle);
    assign sr_enable    = (state_q == StShift);
    assign busy         = (state_q != StIdle);
    assign done_valid   = (state_q == StDone);
    assign done_data    = done_data_q;
    assign sr_direction = msb_q;
    assign ser_out      = sr_enable & (msb_q ? word_q[N-1] : word_q[0]);

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl with a behavioural shift register in the loop.
module tb_shift_ctrl;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_valid = 1'b0;
    logic         msb_first = 1'b0;
    logic         abort = 1'b0;
    logic         done_ready = 1'b0;
    logic [N-1:0] data_in = '0;
    logic [N-1:0] sr_model = '0;
    logic [N-1:0] done_data;
    logic         start_ready, ser_out, sr_direction, sr_enable, busy, done_valid;

    int n_checks = 0;
    int n_fail = 0;

    // Scoreboard queues
    logic         exp_bits[$];
    logic         obs_bits[$];
    logic [N-1:0] exp_words[$];
    logic [N-1:0] last_done = '0;

    int lat, n_en;
    bit got, dir_hi, dir_lo;

    shift_ctrl #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .data_in      (data_in),
        .msb_first    (msb_first),
        .abort        (abort),
        .ser_out      (ser_out),
        .sr_direction (sr_direction),
        .sr_enable    (sr_enable),
        .sr_q         (sr_model),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_data    (done_data),
        .done_ready   (done_ready)
    );

    always #5 clk = ~clk;

    // Behavioural shift register: direction 1 shifts left taking I at bit 0.
    always @(posedge clk) begin
        if (sr_enable) begin
            sr_model <= sr_direction ? {sr_model[N-2:0], ser_out} : {ser_out, sr_model[N-1:1]};
        end
    end

    // Drives one accept from a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_xfer(input logic [N-1:0] d, input logic m);
        exp_words.push_back(d);
        for (int i = 0; i < N; i++) exp_bits.push_back(m ? d[N-1-i] : d[i]);
        data_in     = d;
        msb_first   = m;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        data_in     = '0;
        msb_first   = 1'b0;
    endtask

    // Records serial bits until done_valid (bounded); lat counts cycles after the accept edge.
    task automatic collect();
        lat = 0; n_en = 0; got = 0; dir_hi = 0; dir_lo = 0;
        obs_bits.delete();
        while (!got && lat < 4 * N) begin
            if (sr_enable) begin
                obs_bits.push_back(ser_out);
                n_en++;
                if (sr_direction) dir_hi = 1; else dir_lo = 1;
            end
            if (done_valid) got = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    // Pops expected and observed serial streams into vectors, first bit at MSB.
    task automatic drain(output logic [N-1:0] e, output logic [N-1:0] o);
        e = 'x;
        o = 'x;
        for (int i = 0; i < N; i++) begin
            if (exp_bits.size() > 0) e[N-1-i] = exp_bits.pop_front();
            if (obs_bits.size() > 0) o[N-1-i] = obs_bits.pop_front();
        end
        exp_bits.delete();
        obs_bits.delete();
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, sr_enable, ser_out, sr_direction, done_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 00000",
                     {busy, sr_enable, ser_out, sr_direction, done_valid});
        end
        n_checks++;
        if (done_data !== '0) begin
            n_fail++;
            $display("FAIL reset_done_data: got %h expected 00", done_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({start_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_idle: got ready/busy %b expected 10", {start_ready, busy});
        end
    endtask

    task automatic test_msb_first();
        logic [N-1:0] e, o, w;
        start_xfer(8'hA5, 1'b1);
        collect();
        n_checks++;
        if (!got || lat != N + 1) begin
            n_fail++;
            $display("FAIL msb_latency: got %0d (done %0d) expected %0d", lat, got, N + 1);
        end
        n_checks++;
        if (n_en != N) begin
            n_fail++;
            $display("FAIL msb_enable_cycles: got %0d expected %0d", n_en, N);
        end
        drain(e, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL msb_serial: got %b expected %b", o, e);
        end
        n_checks++;
        if ({dir_hi, dir_lo} !== 2'b10) begin
            n_fail++;
            $display("FAIL msb_direction: got hi/lo %b expected 10", {dir_hi, dir_lo});
        end
        w = exp_words.pop_front();
        n_checks++;
        if (done_data !== w) begin
            n_fail++;
            $display("FAIL msb_done_data: got %h expected %h", done_data, w);
        end
        last_done = w;
        release_done();
        n_checks++;
        if ({done_valid, busy, start_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL msb_release: got valid/busy/ready %b expected 001",
                     {done_valid, busy, start_ready});
        end
    endtask

    task automatic test_lsb_first();
        logic [N-1:0] e, o, w;
        start_xfer(8'h01, 1'b0);
        collect();
        n_checks++;
        if (!got || lat != N + 1) begin
            n_fail++;
            $display("FAIL lsb_latency: got %0d (done %0d) expected %0d", lat, got, N + 1);
        end
        drain(e, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL lsb_serial: got %b expected %b", o, e);
        end
        n_checks++;
        if ({dir_hi, dir_lo} !== 2'b01) begin
            n_fail++;
            $display("FAIL lsb_direction: got hi/lo %b expected 01", {dir_hi, dir_lo});
        end
        w = exp_words.pop_front();
        n_checks++;
        if (done_data !== w) begin
            n_fail++;
            $display("FAIL lsb_done_data: got %h expected %h", done_data, w);
        end
        last_done = w;
        release_done();
    endtask

    task automatic test_hold();
        logic [N-1:0] e, o, w;
        start_xfer(8'h3C, 1'b1);
        collect();
        drain(e, o);
        w = exp_words.pop_front();
        n_checks++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL hold_serial: got %b (done %0d) expected %b", o, got, e);
        end
        // Pulse start_valid and abort while the result waits; neither may disturb DONE.
        for (int c = 0; c < 5; c++) begin
            start_valid = c[0];
            abort       = c[1];
            data_in     = 8'hFF;
            @(negedge clk);
            n_checks++;
            if ({done_valid, start_ready, busy} !== 3'b101 || done_data !== w) begin
                n_fail++;
                $display("FAIL hold_stable c%0d: got valid/ready/busy %b data %h expected 101 %h",
                         c, {done_valid, start_ready, busy}, done_data, w);
            end
        end
        start_valid = 1'b0;
        abort       = 1'b0;
        data_in     = '0;
        last_done   = w;
        release_done();
        @(negedge clk);
        n_checks++;
        if ({busy, sr_enable, done_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_no_queue: got busy/en/valid %b expected 000",
                     {busy, sr_enable, done_valid});
        end
    endtask

    task automatic test_abort();
        bit seen;
        // Abort in the third SHIFT cycle.
        start_xfer(8'hF0, 1'b1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({sr_enable, busy, start_ready} !== 3'b001 || done_data !== last_done) begin
            n_fail++;
            $display("FAIL abort_shift: got en/busy/ready %b data %h expected 001 %h",
                     {sr_enable, busy, start_ready}, done_data, last_done);
        end
        seen = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done_valid) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_no_done: got done_valid 1 expected 0");
        end
        exp_bits.delete();
        void'(exp_words.pop_back());

        // Abort coincident with terminal count (last SHIFT cycle).
        start_xfer(8'h0F, 1'b0);
        repeat (N - 1) @(negedge clk);
        n_checks++;
        if (sr_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_tc_pre: got sr_enable %b expected 1", sr_enable);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        seen = 0;
        repeat (3) begin
            if (done_valid || busy) seen = 1;
            @(negedge clk);
        end
        n_checks++;
        if (seen || done_data !== last_done) begin
            n_fail++;
            $display("FAIL abort_tc: got busy_or_valid %0d data %h expected 0 %h",
                     seen, done_data, last_done);
        end
        exp_bits.delete();
        void'(exp_words.pop_back());

        // Abort during CAPTURE.
        start_xfer(8'h99, 1'b1);
        repeat (N) @(negedge clk);
        n_checks++;
        if ({sr_enable, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_cap_pre: got en/busy %b expected 01", {sr_enable, busy});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, done_valid} !== 2'b00 || done_data !== last_done) begin
            n_fail++;
            $display("FAIL abort_cap: got busy/valid %b data %h expected 00 %h",
                     {busy, done_valid}, done_data, last_done);
        end
        exp_bits.delete();
        void'(exp_words.pop_back());
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] e, o, w;
        start_xfer(8'h96, 1'b1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, sr_enable, ser_out, sr_direction, done_valid} !== 5'b0 || done_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got outs %b data %h expected 00000 00",
                     {busy, sr_enable, ser_out, sr_direction, done_valid}, done_data);
        end
        exp_bits.delete();
        exp_words.delete();
        last_done = '0;
        @(negedge clk);
        reset = 1'b1;
        start_xfer(8'h5A, 1'b0);
        collect();
        n_checks++;
        if (!got || lat != N + 1) begin
            n_fail++;
            $display("FAIL reset_mid_latency: got %0d (done %0d) expected %0d", lat, got, N + 1);
        end
        drain(e, o);
        w = exp_words.pop_front();
        n_checks++;
        if (o !== e || done_data !== w) begin
            n_fail++;
            $display("FAIL reset_mid_xfer: got %b/%h expected %b/%h", o, done_data, e, w);
        end
        last_done = w;
        release_done();
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int n_done;
        int c;
        logic [N-1:0] w;
        exp_words.delete();
        n_done      = 0;
        done_ready  = 1'b1;
        start_valid = 1'b1;
        data_in     = 8'hC3;
        msb_first   = 1'b1;
        c = 0;
        // Keep requesting for a while, then stop and let the last word drain.
        while (c < 4 * (N + 3) + 3 * N && (c < 4 * (N + 3) || busy)) begin
            if (c == 4 * (N + 3)) start_valid = 1'b0;
            if (done_valid) begin
                w = (exp_words.size() > 0) ? exp_words.pop_front() : 'x;
                n_done++;
                n_checks++;
                if (done_data !== w) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h expected %h", n_done, done_data, w);
                end
            end
            if (start_ready && start_valid) begin
                acc_cyc.push_back(c);
                exp_words.push_back(data_in);
            end
            @(negedge clk);
            c++;
            data_in   = data_in + 8'h11;
            msb_first = ~msb_first;
        end
        done_ready = 1'b0;
        n_checks++;
        if (acc_cyc.size() < 4 || exp_words.size() != 0 || n_done != acc_cyc.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got accepts %0d done %0d left %0d expected >=4 equal 0",
                     acc_cyc.size(), n_done, exp_words.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != N + 3) begin
                n_fail++;
                $display("FAIL b2b_interval%0d: got %0d expected %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], N + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_hold();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
